// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes,
// line levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Zero-extension to 9 bits leaves the XOR reduction unchanged.
  function automatic logic calc_par(
    input logic [8:0] d,
    input logic       odd
  );
    return (^d) ^ (odd == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_sel.sv
// Line-level select: maps frame state to the
// level driven onto the serial line.
module uart_bit_sel
  import uart_pkg::*;
(
  input  state_e state,
  input  logic   data_lsb,
  input  logic   par_val,
  output logic   line
);

  // Start is low, data/parity pass through, all else idles high.
  always_comb begin
    line = LINE_IDLE;
    unique case (state)
      S_START:  line = LINE_START;
      S_DATA:   line = data_lsb;
      S_PARITY: line = par_val;
      default:  line = LINE_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: valid/ready word in,
// start/data/parity/stop frame out on a registered line.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  par_en,
  input  logic                  par_odd,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST =
    CW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [CW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  pen_q, pen_d;
  logic                  s2_q, s2_d;
  logic                  line_d;
  logic                  accept;
  logic                  baud_done;

  assign tx_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q != S_IDLE);
  assign accept    = tx_valid && tx_ready;
  assign baud_done = (baud_q == BAUD_LAST);

  // Next-state: FSM, baud divider, bit counter, shifter.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    s2_d    = s2_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (accept) begin
          shift_d = tx_data;
          par_d   = calc_par(9'(tx_data), par_odd);
          pen_d   = par_en;
          s2_d    = stop2;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (s2_q && bit_q == '0) begin
            bit_d = CW'(1);
          end else begin
            bit_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level follows the state being entered, so the
  // start bit appears on the accepting edge.
  uart_bit_sel u_bit_sel (
    .state    (state_d),
    .data_lsb (shift_d[0]),
    .par_val  (par_d),
    .line     (line_d)
  );

  // State, counters, frame latches and line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      s2_q    <= 1'b0;
      tx_out  <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      s2_q    <= s2_d;
      tx_out  <= line_d;
    end
  end

endmodule
